// File: rtl/booth_mult_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the result consumer.
// The arbiter takes the slave side; requesters and the consumer take the master side.
interface booth_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_result;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one serially loaded Booth multiplier among NUM_REQ
// requesters and returns each product with its owner's ID on a valid/ready port.
module booth_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 17,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    booth_mult_arbiter_if.slave bus,
    output logic                busy,
    output logic                mul_start,
    output logic [15:0]         mul_data_in,
    input  logic [31:0]         mul_result
);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, START, LOAD_A, LOAD_B, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_found;
    logic [CNT_W-1:0]   wait_cnt;
    logic signed [15:0] sel_a;
    logic signed [15:0] sel_b;
    logic signed [15:0] op_a;
    logic signed [15:0] op_b;
    logic signed [31:0] result;
    logic [ID_W-1:0]    result_id;

    // Lowest pending index at or after rr_ptr wins; otherwise wrap to the lowest pending index.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) gnt_idx = ID_W'(i);
        end
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_a = bus.req_a[16*i +: 16];
                sel_b = bus.req_b[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = START;
            START:   state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        if (state == IDLE && gnt_found && !rst) bus.req_ready = NUM_REQ'(1) << gnt_idx;
        busy           = (state != IDLE);
        mul_start      = (state == START);
        bus.resp_valid = (state == RESP);
        case (state)
            LOAD_A:  mul_data_in = op_a;
            LOAD_B:  mul_data_in = op_b;
            default: mul_data_in = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            result    <= '0;
            result_id <= '0;
        end else begin
            if (state == IDLE && gnt_found)
                rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (state == LOAD_B)
                wait_cnt <= CNT_LOAD;
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            if (state == WAIT && wait_cnt == '0) begin
                result    <= mul_result;
                result_id <= gnt_id;
            end
        end
    end

    // Operand capture at grant; these hold data only and need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && gnt_found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            gnt_id <= gnt_idx;
        end
    end

    assign bus.resp_result = result;
    assign bus.resp_id     = result_id;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: behavioural multiplier stub, round-robin reference model,
// directed scenarios and randomized transactions.
module tb_booth_mult_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int MUL_LATENCY = 17;
    localparam int ID_W        = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        mul_start;
    logic [15:0] mul_data_in;
    logic [31:0] mul_result;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int model_ptr = 0;

    logic signed [15:0] a_op [NUM_REQ];
    logic signed [15:0] b_op [NUM_REQ];

    booth_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    booth_mult_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .ID_W(ID_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .mul_start(mul_start),
        .mul_data_in(mul_data_in),
        .mul_result(mul_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign bus.req_a[16*i +: 16] = a_op[i];
        assign bus.req_b[16*i +: 16] = b_op[i];
    end

    // Multiplier stub: start, A, B on data_in; product visible only in the cycle
    // MUL_LATENCY after the B cycle, and the bitwise inverse at all other times.
    logic signed [15:0] ma = '0;
    logic signed [15:0] mb = '0;
    logic signed [31:0] mprod;
    int mph = 0;
    int mcnt = 0;
    assign mprod      = ma * mb;
    assign mul_result = (mcnt == 1) ? mprod : ~mprod;
    always @(posedge clk) begin
        if (mcnt != 0) mcnt <= mcnt - 1;
        if (mul_start) mph <= 1;
        else if (mph == 1) begin ma <= mul_data_in; mph <= 2; end
        else if (mph == 2) begin mb <= mul_data_in; mph <= 0; mcnt <= MUL_LATENCY; end
    end

    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (mul_start === 1'b1) begin
            tests++;
            if (prev_start) begin
                fails++;
                $display("FAIL start_pulse: mul_start high in two consecutive cycles at cycle %0d, expected single pulse", cyc);
            end
        end
        prev_start <= (mul_start === 1'b1);
    end

    function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (ptr + k) % NUM_REQ;
            if (v[idx[ID_W-1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic wait_grant(output int g, output int t);
        g = -1;
        t = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) g = i;
                t = cyc;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL grant_timeout: req_ready=%b after 100 cycles, expected a grant", bus.req_ready);
    endtask

    task automatic wait_resp(output int t);
        t = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                t = cyc;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL resp_timeout: resp_valid=%b after 100 cycles, expected 1", bus.resp_valid);
    endtask

    task automatic do_txn(input int bp, input bit drop, output int g, output int t,
                          output int th, output logic [31:0] res);
        int tr;
        int eg;
        logic [ID_W-1:0] gi;
        logic signed [15:0] ea;
        logic signed [15:0] eb;
        logic signed [31:0] ep;
        th  = -1;
        res = 'x;
        wait_grant(g, t);
        if (g < 0) return;
        gi = ID_W'(g);
        eg = exp_grant(bus.req_valid, model_ptr);
        tests++;
        if (g !== eg || !$onehot(bus.req_ready)) begin
            fails++;
            $display("FAIL grant_order: req_ready=%b, expected one-hot grant to requester %0d", bus.req_ready, eg);
        end
        ea = a_op[gi];
        eb = b_op[gi];
        ep = ea * eb;
        model_ptr = (g + 1) % NUM_REQ;
        @(posedge clk);
        #1 if (drop) bus.req_valid[gi] = 1'b0;
        wait_resp(tr);
        if (tr < 0) return;
        res = bus.resp_result;
        tests++;
        if (tr - t != MUL_LATENCY + 4) begin
            fails++;
            $display("FAIL resp_latency: got %0d cycles, expected %0d", tr - t, MUL_LATENCY + 4);
        end
        tests++;
        if (bus.resp_result !== ep || bus.resp_id !== gi) begin
            fails++;
            $display("FAIL resp_value: got id=%0d result=%h, expected id=%0d result=%h", bus.resp_id, bus.resp_result, gi, ep);
        end
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            tests++;
            if (bus.resp_valid !== 1'b1 || bus.resp_result !== ep || bus.resp_id !== gi || bus.req_ready !== '0) begin
                fails++;
                $display("FAIL resp_hold: got valid=%b id=%0d result=%h req_ready=%b, expected valid=1 id=%0d result=%h req_ready=0",
                         bus.resp_valid, bus.resp_id, bus.resp_result, bus.req_ready, gi, ep);
            end
        end
        bus.resp_ready = 1'b1;
        th = cyc;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid  = '1;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin a_op[i] = '0; b_op[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.req_ready !== '0) begin fails++; $display("FAIL reset_req_ready: got %b, expected 0", bus.req_ready); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b, expected 0", bus.resp_valid); end
        tests++; if (bus.resp_id !== '0) begin fails++; $display("FAIL reset_resp_id: got %0d, expected 0", bus.resp_id); end
        tests++; if (bus.resp_result !== '0) begin fails++; $display("FAIL reset_resp_result: got %h, expected 0", bus.resp_result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests++; if (mul_start !== 1'b0) begin fails++; $display("FAIL reset_mul_start: got %b, expected 0", mul_start); end
        tests++; if (mul_data_in !== '0) begin fails++; $display("FAIL reset_mul_data_in: got %h, expected 0", mul_data_in); end
        @(posedge clk);
        #1 rst = 1'b0;
        bus.req_valid = '0;
        model_ptr = 0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || bus.req_ready !== '0) begin fails++; $display("FAIL post_reset_idle: got busy=%b req_ready=%b, expected 0 and 0", busy, bus.req_ready); end
    endtask

    task automatic test_single();
        int g;
        int t;
        logic        exp_start;
        logic        exp_valid;
        logic [15:0] exp_data;
        a_op[0] = 16'sd10;
        b_op[0] = 16'sd13;
        @(posedge clk);
        #1 bus.req_valid = 4'b0001;
        wait_grant(g, t);
        if (g < 0) return;
        tests++; if (g !== 0) begin fails++; $display("FAIL single_grant: got requester %0d, expected 0", g); end
        model_ptr = 1;
        @(posedge clk);
        #1 bus.req_valid = '0;
        for (int c = 1; c <= MUL_LATENCY + 4; c++) begin
            @(negedge clk);
            exp_start = (c == 1);
            exp_valid = (c == MUL_LATENCY + 4);
            exp_data  = (c == 2) ? 16'd10 : (c == 3) ? 16'd13 : 16'd0;
            tests++; if (mul_start !== exp_start) begin fails++; $display("FAIL single_mul_start: T+%0d got %b, expected %b", c, mul_start, exp_start); end
            tests++; if (mul_data_in !== exp_data) begin fails++; $display("FAIL single_mul_data: T+%0d got %0d, expected %0d", c, mul_data_in, exp_data); end
            tests++; if (bus.resp_valid !== exp_valid) begin fails++; $display("FAIL single_resp_valid: T+%0d got %b, expected %b", c, bus.resp_valid, exp_valid); end
        end
        tests++;
        if (bus.resp_result !== 32'h00000082 || bus.resp_id !== '0) begin
            fails++;
            $display("FAIL single_result: got id=%0d result=%h, expected id=0 result=00000082", bus.resp_id, bus.resp_result);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_return_idle: got busy=%b, expected 0", busy); end
    endtask

    task automatic test_signed();
        int g, t, th;
        logic [31:0] r;
        logic [31:0] want [3];
        logic signed [15:0] av [3];
        logic signed [15:0] bv [3];
        av[0] = -16'sd3;    bv[0] = 16'sd7;      want[0] = 32'hFFFFFFEB;
        av[1] = -16'sd32768; bv[1] = -16'sd32768; want[1] = 32'h40000000;
        av[2] = 16'sd32767; bv[2] = -16'sd32768; want[2] = 32'hC0008000;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1 a_op[2] = av[n];
            b_op[2] = bv[n];
            bus.req_valid = 4'b0100;
            do_txn(0, 1'b1, g, t, th, r);
            tests++;
            if (r !== want[n] || g !== 2) begin
                fails++;
                $display("FAIL signed_product_%0d: got id=%0d result=%h, expected id=2 result=%h", n, g, r, want[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        int g, t, th, g2, t2, th2;
        logic [31:0] r;
        a_op[1] = 16'sd100;  b_op[1] = -16'sd5;
        a_op[2] = -16'sd77;  b_op[2] = -16'sd91;
        @(posedge clk);
        #1 bus.req_valid = 4'b0110;
        do_txn(10, 1'b1, g, t, th, r);
        do_txn(0, 1'b1, g2, t2, th2, r);
        tests++;
        if (t2 != th + 1) begin
            fails++;
            $display("FAIL bp_next_grant: got grant at cycle %0d, expected %0d", t2, th + 1);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_round_robin();
        int g, t, th, tp;
        logic [31:0] r;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            a_op[i] = 16'(i * 1000 + 17);
            b_op[i] = 16'(-(i * 321) - 5);
        end
        bus.req_valid = '1;
        tp = 0;
        for (int n = 0; n < NUM_REQ + 1; n++) begin
            do_txn(0, 1'b0, g, t, th, r);
            tests++;
            if (g !== n % NUM_REQ) begin fails++; $display("FAIL rr_order_%0d: got requester %0d, expected %0d", n, g, n % NUM_REQ); end
            if (n > 0) begin
                tests++;
                if (t - tp != MUL_LATENCY + 5) begin fails++; $display("FAIL rr_spacing_%0d: got %0d cycles, expected %0d", n, t - tp, MUL_LATENCY + 5); end
            end
            tp = t;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int g, t, th;
        bit ghost;
        logic [31:0] r;
        a_op[2] = 16'sd1234;
        b_op[2] = 16'sd4321;
        @(posedge clk);
        #1 bus.req_valid = 4'b0100;
        wait_grant(g, t);
        if (g < 0) return;
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || mul_start !== 1'b0 || bus.resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got busy=%b mul_start=%b resp_valid=%b, expected 0 0 0", busy, mul_start, bus.resp_valid);
        end
        ghost = 1'b0;
        repeat (MUL_LATENCY + 8) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1 || busy === 1'b1) ghost = 1'b1;
        end
        tests++; if (ghost) begin fails++; $display("FAIL midreset_ghost: got activity after reset, expected none"); end
        a_op[1] = -16'sd9;  b_op[1] = 16'sd11;
        a_op[3] = 16'sd25;  b_op[3] = 16'sd4;
        @(posedge clk);
        #1 bus.req_valid = 4'b1010;
        do_txn(0, 1'b1, g, t, th, r);
        tests++; if (g !== 1) begin fails++; $display("FAIL midreset_first_grant: got requester %0d, expected 1", g); end
        do_txn(0, 1'b1, g, t, th, r);
        tests++; if (g !== 3) begin fails++; $display("FAIL midreset_second_grant: got requester %0d, expected 3", g); end
        bus.req_valid = '0;
    endtask

    task automatic test_wrap();
        int g, t, th;
        logic [31:0] r;
        apply_reset();
        a_op[0] = 16'sd300;  b_op[0] = -16'sd2;
        a_op[3] = -16'sd40;  b_op[3] = -16'sd40;
        bus.req_valid = 4'b1000;
        do_txn(0, 1'b1, g, t, th, r);
        tests++; if (g !== 3) begin fails++; $display("FAIL wrap_first: got requester %0d, expected 3", g); end
        bus.req_valid = 4'b1001;
        do_txn(0, 1'b1, g, t, th, r);
        tests++; if (g !== 0) begin fails++; $display("FAIL wrap_after_ptr: got requester %0d, expected 0", g); end
        do_txn(0, 1'b1, g, t, th, r);
        tests++; if (g !== 3) begin fails++; $display("FAIL wrap_then_three: got requester %0d, expected 3", g); end
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        int g, t, th;
        logic [31:0] r;
        @(posedge clk);
        #1;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                a_op[i] = 16'($urandom);
                b_op[i] = 16'($urandom);
            end
            bus.req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            do_txn(int'($urandom_range(0, 4)), 1'b1, g, t, th, r);
        end
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_signed();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        test_wrap();
        test_random();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin arbiter and sequencer sharing one 16x16 Booth multiplier among NUM_REQ requesters. Accepts one signed operand pair per grant. Drives the multiplier's serial load protocol: start pulse, operand A, then operand B on the shared 16-bit data input. Waits a fixed latency, captures the 32-bit product, and returns it with the requester's ID over a valid/ready response port.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- MUL_LATENCY, 17: cycles from the LOAD_B cycle to a valid product on mul_result (>=1).
- ID_W, $clog2(NUM_REQ): width of resp_id.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request; must stay high until accepted.
- req_a  in  16*NUM_REQ  operand A, two's complement; requester i at bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot accept pulse, one cycle.
- resp_valid  out  1  product available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  ID_W  index of the requester that owns resp_result.
- resp_result  out  32  signed product.
- busy  out  1  high in every state except IDLE.
- mul_start  out  1  to multiplier start.
- mul_data_in  out  16  to multiplier data_in.
- mul_result  in  32  from multiplier result.

## Operation
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g] is combinational and high that cycle only.
  - Capture req_a/req_b slice g and g into registers; rr_ptr <= (g+1) mod NUM_REQ; go to START.
  - If no request, stay in IDLE.
- START: mul_start=1, mul_data_in=0. Go to LOAD_A.
- LOAD_A: mul_start=0, mul_data_in=captured A. Go to LOAD_B.
- LOAD_B: mul_data_in=captured B; load wait counter with MUL_LATENCY-1. Go to WAIT.
- WAIT:
  - mul_data_in=0; decrement the counter.
  - When the counter is 0: resp_result <= mul_result, resp_id <= g, go to RESP.
- RESP:
  - resp_valid=1; resp_result and resp_id are held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE.
- Arithmetic: the arbiter does not modify operands or the product. Sign is the multiplier's concern; the product is passed bit-exact.
- The pointer advances only on a grant. A requester that drops req_valid before its grant loses nothing and gets no slot.
- Requests are ignored outside IDLE; req_ready stays 0 there.
- Reset, any state, including mid-sequence:
  - State IDLE, rr_ptr=0, wait counter 0.
  - In-flight operation is discarded; no response is produced.
- Output values on reset: req_ready=0, resp_valid=0, resp_id=0, resp_result=0, busy=0, mul_start=0, mul_data_in=0.

## Timing
- Accept at cycle T (req_ready high). Then START at T+1, LOAD_A at T+2, LOAD_B at T+3, WAIT from T+4 through T+3+MUL_LATENCY.
- resp_valid first high at T+4+MUL_LATENCY; default latency is 21 cycles.
- Response handshake at cycle H returns the block to IDLE at H+1. The earliest next accept is H+1, so back-to-back throughput is 1 op per MUL_LATENCY+5 cycles with resp_ready tied high.
- Simultaneous requests: exactly one grant per IDLE cycle, round-robin order. With all NUM_REQ requests held high, grants cycle 0,1,2,3,0,...
- resp_ready high outside RESP has no effect.
- mul_start is never high in two consecutive cycles.

## Test plan
- Single request: after reset, requester 0 presents A=10, B=13.
  - req_ready[0] high at T; mul_start high at T+1.
  - mul_data_in=10 at T+2, 13 at T+3.
  - resp_valid at T+21 with resp_result=32'h00000082, resp_id=0.
- Signed pass-through: requester 2 presents A=-3, B=7 → resp_result=32'hFFFFFFEB, resp_id=2.
  - Run against a behavioral signed multiplier model with MUL_LATENCY=17.
- Round-robin fairness: all 4 req_valid held high with distinct operands, resp_ready=1.
  - Grants occur in order 0,1,2,3,0, spaced 22 cycles apart.
  - Each resp_id matches the product of its operands.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid.
  - resp_valid, resp_id and resp_result are stable; req_ready stays 0 despite pending requests.
  - The next grant comes the cycle after resp_ready rises.
- Reset mid-operation: assert rst during WAIT.
  - Next cycle: busy=0, mul_start=0, resp_valid=0, and no response ever appears for the dropped request.
  - With requesters 1 and 3 pending, the next grant goes to requester 1, since rr_ptr resets to 0.
- Pointer wrap: only requester 3 is active, then requesters 0 and 3 are both pending.
  - After the grant to 3, rr_ptr=0, so requester 0 is granted before 3.
